// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a
// per-register busy scoreboard used by the pipeline for RAW hazard detection.
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic [NRD*$clog2(NREGS)-1:0]      rs_addr_i,
   output logic [NRD*XLEN-1:0]               rs_data_o,
   output logic [NRD-1:0]                    rs_busy_o,
   input  logic [NWR-1:0]                    wr_en_i,
   input  logic [NWR*$clog2(NREGS)-1:0]      wr_addr_i,
   input  logic [NWR*XLEN-1:0]               wr_data_i,
   input  logic                              iss_valid_i,
   input  logic [$clog2(NREGS)-1:0]          iss_rd_i,
   output logic [NREGS-1:0]                  busy_vec_o
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val [NREGS];
   logic [AW-1:0]    rd_addr [NRD];

   // Per-register write decode; ascending port scan lets the highest-index port win a collision.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NREGS; i++) begin
         wr_val[i] = '0;
      end
      for (int j = 0; j < NWR; j++) begin
         if (wr_en_i[j]) begin
            wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
            wr_val[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
         end
      end
      if (ZERO_REG != 0) begin
         wr_hit[0] = 1'b0;
      end
   end

   // Scoreboard next state: a new issue beats a same-cycle writeback since the new producer is still pending.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREGS; i++) begin
         if (iss_valid_i && (iss_rd_i == AW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (wr_hit[i]) begin
            busy_d[i] = 1'b0;
         end
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // Register array and scoreboard state; reset ignores write and issue inputs.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wr_hit[i]) begin
               regs_q[i] <= wr_val[i];
            end
         end
         busy_q <= busy_d;
      end
   end

   // Split the packed read address bus into per-port addresses.
   always_comb begin
      for (int k = 0; k < NRD; k++) begin
         rd_addr[k] = rs_addr_i[k*AW +: AW];
      end
   end

   // Zero-latency read ports; a forwarded write also masks the busy bit because its data is already here.
   always_comb begin
      rs_data_o = '0;
      rs_busy_o = '0;
      for (int k = 0; k < NRD; k++) begin
         rs_data_o[k*XLEN +: XLEN] = regs_q[rd_addr[k]];
         rs_busy_o[k]              = busy_q[rd_addr[k]];
         if ((BYPASS != 0) && wr_hit[rd_addr[k]]) begin
            rs_data_o[k*XLEN +: XLEN] = wr_val[rd_addr[k]];
            rs_busy_o[k]              = 1'b0;
         end
         if ((ZERO_REG != 0) && (rd_addr[k] == '0)) begin
            rs_data_o[k*XLEN +: XLEN] = '0;
            rs_busy_o[k]              = 1'b0;
         end
      end
   end

   assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: table of vectors on the default bypassing
// configuration, plus hand sequences for the non-bypass and wide/3-port builds.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  we;
   logic [9:0]  wa;
   logic [63:0] wd;
   logic        iv;
   logic [4:0]  ird;
   logic [9:0]  ra;

   logic [63:0] b_rd;
   logic [1:0]  b_rb;
   logic [31:0] b_bv;
   logic [63:0] nb_rd;
   logic [1:0]  nb_rb;
   logic [31:0] nb_bv;

   logic         w_we;
   logic [3:0]   w_wa;
   logic [63:0]  w_wd;
   logic         w_iv;
   logic [3:0]   w_ird;
   logic [11:0]  w_ra;
   logic [191:0] w_rd;
   logic [2:0]   w_rb;
   logic [15:0]  w_bv;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .rs_addr_i(ra), .rs_data_o(b_rd), .rs_busy_o(b_rb),
      .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd), .iss_valid_i(iv), .iss_rd_i(ird),
      .busy_vec_o(b_bv));

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk_i(clk), .rst_n_i(rst_n), .rs_addr_i(ra), .rs_data_o(nb_rd), .rs_busy_o(nb_rb),
      .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd), .iss_valid_i(iv), .iss_rd_i(ird),
      .busy_vec_o(nb_bv));

   regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1), .BYPASS(1), .ZERO_REG(1)) dut_w (
      .clk_i(clk), .rst_n_i(rst_n), .rs_addr_i(w_ra), .rs_data_o(w_rd), .rs_busy_o(w_rb),
      .wr_en_i(w_we), .wr_addr_i(w_wa), .wr_data_i(w_wd), .iss_valid_i(w_iv), .iss_rd_i(w_ird),
      .busy_vec_o(w_bv));

   typedef struct packed {
      logic        rst_n;
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] ed0;
      logic [31:0] ed1;
      logic        eb0;
      logic        eb1;
      logic [31:0] ebv;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(
      input logic r, input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
      input logic [4:0] a1, input logic [31:0] d1, input logic v, input logic [4:0] rd,
      input logic [4:0] r0, input logic [4:0] r1, input logic [31:0] x0, input logic [31:0] x1,
      input logic b0, input logic b1, input logic [31:0] bv);
      vec_t t;
      t.rst_n = r;  t.we = e;   t.wa0 = a0; t.wd0 = d0; t.wa1 = a1; t.wd1 = d1;
      t.iv = v;     t.ird = rd; t.ra0 = r0; t.ra1 = r1; t.ed0 = x0; t.ed1 = x1;
      t.eb0 = b0;   t.eb1 = b1; t.ebv = bv;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; we = '0; wa = '0; wd = '0; iv = 1'b0; ird = '0; ra = '0;
      w_we = 1'b0; w_wa = '0; w_wd = '0; w_iv = 1'b0; w_ird = '0; w_ra = '0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);

      //    rst we  wa0 wd0            wa1 wd1            iv ird ra0 ra1 ed0            ed1            b0 b1 busy_vec
      tbl[0]  = mk(1, 2'b01, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0, 1, 2, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
      tbl[1]  = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
      tbl[2]  = mk(1, 2'b10, 0, 32'h0,        5, 32'hCAFEBABE, 0, 0, 1, 5, 32'hDEADBEEF, 32'hCAFEBABE, 0, 0, 32'h0);
      tbl[3]  = mk(1, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 5, 32'h0,        32'hCAFEBABE, 0, 0, 32'h0);
      tbl[4]  = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
      tbl[5]  = mk(1, 2'b11, 3, 32'h11111111, 3, 32'h22222222, 0, 0, 3, 3, 32'h22222222, 32'h22222222, 0, 0, 32'h0);
      tbl[6]  = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        1, 7, 3, 5, 32'h22222222, 32'hCAFEBABE, 0, 0, 32'h0);
      tbl[7]  = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 7, 7, 32'h0,        32'h0,        1, 1, 32'h80);
      tbl[8]  = mk(1, 2'b01, 7, 32'h7,        0, 32'h0,        0, 0, 7, 3, 32'h7,        32'h22222222, 0, 0, 32'h80);
      tbl[9]  = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 7, 7, 32'h7,        32'h7,        0, 0, 32'h0);
      tbl[10] = mk(1, 2'b10, 0, 32'h0,        7, 32'h77,       1, 7, 7, 1, 32'h77,       32'hDEADBEEF, 0, 0, 32'h0);
      tbl[11] = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 7, 1, 32'h77,       32'hDEADBEEF, 1, 0, 32'h80);
      tbl[12] = mk(1, 2'b11, 9, 32'h99,       7, 32'h70,       1, 9, 9, 7, 32'h99,       32'h70,       0, 0, 32'h80);
      tbl[13] = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 9, 7, 32'h99,       32'h70,       1, 0, 32'h200);
      tbl[14] = mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 2, 9, 1, 32'h99,       32'hDEADBEEF, 1, 0, 32'h200);
      tbl[15] = mk(1, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0, 9, 1, 32'h0,        32'h0,        0, 0, 32'h0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n;
         we    = tbl[i].we;
         wa    = {tbl[i].wa1, tbl[i].wa0};
         wd    = {tbl[i].wd1, tbl[i].wd0};
         iv    = tbl[i].iv;
         ird   = tbl[i].ird;
         ra    = {tbl[i].ra1, tbl[i].ra0};
         #1;
         n_vec++;
         chk($sformatf("row%0d rs_data0", i), {32'h0, b_rd[31:0]},  {32'h0, tbl[i].ed0});
         chk($sformatf("row%0d rs_data1", i), {32'h0, b_rd[63:32]}, {32'h0, tbl[i].ed1});
         chk($sformatf("row%0d rs_busy0", i), {63'h0, b_rb[0]},     {63'h0, tbl[i].eb0});
         chk($sformatf("row%0d rs_busy1", i), {63'h0, b_rb[1]},     {63'h0, tbl[i].eb1});
         chk($sformatf("row%0d busy_vec", i), {32'h0, b_bv},        {32'h0, tbl[i].ebv});
      end

      // Non-bypass build: issue x5, then write it while reading; old value and busy bit show until the edge.
      @(negedge clk);
      idle();
      iv = 1'b1; ird = 5'd5; ra = {5'd5, 5'd0};
      #1;
      n_vec++;
      chk("nb pre-issue data", {32'h0, nb_rd[63:32]}, 64'h0);
      chk("nb pre-issue busy", {63'h0, nb_rb[1]}, 64'h0);

      @(negedge clk);
      idle();
      we = 2'b10; wa = {5'd5, 5'd0}; wd = {32'hCAFEBABE, 32'h0}; ra = {5'd5, 5'd0};
      #1;
      n_vec++;
      chk("nb same-cycle data", {32'h0, nb_rd[63:32]}, 64'h0);
      chk("nb same-cycle busy", {63'h0, nb_rb[1]}, 64'h1);
      chk("nb busy_vec set", {32'h0, nb_bv}, 64'h20);
      chk("b bypass data", {32'h0, b_rd[63:32]}, 64'hCAFEBABE);
      chk("b bypass busy mask", {63'h0, b_rb[1]}, 64'h0);

      @(negedge clk);
      idle();
      ra = {5'd5, 5'd0};
      #1;
      n_vec++;
      chk("nb after-edge data", {32'h0, nb_rd[63:32]}, 64'hCAFEBABE);
      chk("nb after-edge busy", {63'h0, nb_rb[1]}, 64'h0);
      chk("nb busy_vec clear", {32'h0, nb_bv}, 64'h0);

      // Wide 16x64, three read ports, one write port.
      @(negedge clk);
      idle();
      w_we = 1'b1; w_wa = 4'd15; w_wd = 64'h0123456789ABCDEF;
      w_iv = 1'b1; w_ird = 4'd3;
      w_ra = {4'd15, 4'd15, 4'd15};
      #1;
      n_vec++;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wide bypass port%0d", k), w_rd[k*64 +: 64], 64'h0123456789ABCDEF);
      end
      chk("wide busy_vec pre", {48'h0, w_bv}, 64'h0);

      @(negedge clk);
      idle();
      w_ra = {4'd0, 4'd15, 4'd15};
      #1;
      n_vec++;
      chk("wide read port0", w_rd[63:0],    64'h0123456789ABCDEF);
      chk("wide read port1", w_rd[127:64],  64'h0123456789ABCDEF);
      chk("wide read x0",    w_rd[191:128], 64'h0);
      chk("wide busy_vec",   {48'h0, w_bv}, 64'h0008);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read RV32I register file.
- Generalises the number of registers, read ports and write ports.
- Adds an optional write-to-read bypass and a per-register busy scoreboard so a pipelined core can detect RAW hazards.
- Sits between decode (read/issue) and writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2; AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never marked busy.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- rs_addr_i  in  NRD*AW  read addresses; port k uses slice [k*AW +: AW].
- rs_data_o  out  NRD*XLEN  read data, combinational; port k uses slice [k*XLEN +: XLEN].
- rs_busy_o  out  NRD  scoreboard busy bit of each read address, combinational.
- wr_en_i  in  NWR  per-port write enable.
- wr_addr_i  in  NWR*AW  write addresses.
- wr_data_i  in  NWR*XLEN  write data.
- iss_valid_i  in  1  an instruction with a destination issues this cycle.
- iss_rd_i  in  AW  destination register of the issuing instruction.
- busy_vec_o  out  NREGS  registered busy bits, bit i for register i.

Behaviour:
- Reset: on a rising edge with rst_n_i=0, all registers are set to 0 and busy_vec_o is cleared to 0. Write and issue inputs are ignored that cycle. Reset mid-operation discards pending busy marks.
- Write:
  - On the rising edge with wr_en_i[j]=1, reg[wr_addr_j] <= wr_data_j.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Write collision: when several enabled ports target the same address, the highest-index port wins for both the data and the bypass.
- Read:
  - rs_data_o[k] = reg[rs_addr_k], with zero latency.
  - With ZERO_REG=1 and address 0, the output is 0 regardless of stored value or bypass.
- Bypass (BYPASS=1): if any enabled write port matches rs_addr_k (address nonzero or ZERO_REG=0), rs_data_o[k] returns the winning wr_data in the same cycle. With BYPASS=0, the old value is returned until the next edge.
- Scoreboard, per register i on each rising edge:
  - set if iss_valid_i and iss_rd_i==i;
  - else clear if any wr_en_i[j] with wr_addr_j==i;
  - else hold.
  - Issue and writeback to the same register in the same cycle: set wins, because the new producer is pending.
  - With ZERO_REG=1, busy_vec_o[0] is constant 0.
- rs_busy_o[k]:
  - = busy_vec_o[rs_addr_k], except it reads 0 when a same-cycle write to that address is enabled and BYPASS=1, since the data is already available.
  - With BYPASS=0, it reflects the registered bit.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- All reads and rs_busy_o are purely combinational from current state and inputs. No other latency exists.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset, then write x1=32'hDEADBEEF on port 0; next cycle read x1 on port 0 -> rs_data_o[0]=32'hDEADBEEF. Also drive rst_n_i=0 for one edge -> reads return 0 and busy_vec_o=0.
- Bypass: with BYPASS=1, in the same cycle write x5=32'hCAFEBABE and read x5 on port 1 -> 32'hCAFEBABE combinationally before the edge. With BYPASS=0, the old value 0 is returned until after the edge.
- x0: write 32'hFFFFFFFF to x0 with both ports; issue rd=0 -> reads of x0 return 0 and busy_vec_o[0]=0.
- Collision: port 0 writes x3=32'h11111111 and port 1 writes x3=32'h22222222 in the same cycle -> x3=32'h22222222 and the bypass also returns 32'h22222222.
- Scoreboard:
  - issue rd=7 -> busy_vec_o[7]=1 next cycle, and rs_busy_o=1 for reads of x7;
  - writeback x7=32'h7 -> bit cleared next cycle, and rs_busy_o=0 in the writeback cycle when BYPASS=1;
  - issue rd=7 together with writeback x7 -> bit stays 1.
- Parametrisation: NREGS=16, NRD=3, NWR=1, XLEN=64 -> write x15=64'h0123456789ABCDEF; all three ports read x15 -> identical 64-bit value.
